mem_dump_reader: RTL and testbench

//  Readback side of the memory-override path: once the CPU is held, it walks RAM over a sync read port.

---
 rtl/mem_dump_pkg.sv | 15 +
 rtl/mem_dump_reader_if.sv | 24 ++
 rtl/mem_dump_out_reg.sv | 36 +++
 rtl/mem_dump_reader.sv | 131 +++++++++++++
 tb/tb_mem_dump_reader.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_dump_pkg.sv
// Shared types and sizing helpers for the memory dump reader.
// Default data width and RAM depth used by the reader and its bench.
package mem_dump_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 16;

  typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, HOLD, FIN} state_t;

  // Address width for a RAM of the given depth (at least 1 bit).
  function automatic int addr_w(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/mem_dump_reader_if.sv
// RAM read port plus the {addr,data} valid/ready stream.
// master = reader side, slave = RAM/sink side.
interface mem_dump_reader_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;

  modport master (
    output rd_en, rd_addr, out_valid, out_addr, out_data,
    input  rd_data, out_ready
  );

  modport slave (
    input  rd_en, rd_addr, out_valid, out_addr, out_data,
    output rd_data, out_ready
  );
endinterface

// File: rtl/mem_dump_out_reg.sv
// Valid/ready holding register for one streamed {addr,data} word.
// Flush (abort) wins over load, load wins over accept.
module mem_dump_out_reg #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic              flush,
  input  logic              ready,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              valid,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  // Hold the word stable until the sink accepts it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid <= 1'b0;
      addr  <= '0;
      data  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      addr  <= load_addr;
      data  <= load_data;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_dump_reader.sv
// Walks RAM over a sync read port and streams each word as {addr,data}.
// One read outstanding at most: ISSUE -> CAPTURE -> HOLD per word.
// Optional: define MEM_DUMP_CHECKSUM_EN to add checksum/checksum_valid.
module mem_dump_reader
  import mem_dump_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int DEPTH  = DEF_DEPTH,
  localparam int ADDR_W = addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W:0]   start_addr,
  input  logic [ADDR_W:0]   end_addr,
  output logic              busy,
  output logic              done,
`ifdef MEM_DUMP_CHECKSUM_EN
  output logic [DATA_W-1:0] checksum,
  output logic              checksum_valid,
`endif
  mem_dump_reader_if.master bus
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);

  state_t            state_q, state_d;
  logic [ADDR_W:0]   cnt_q, bound_q;
  logic [ADDR_W:0]   end_clamped;
  logic              start_acc, accept, last, rd_en, load;
  logic              out_valid;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;

  // The bound is clamped once, when the dump is accepted, so the walk never
  // touches an address at or beyond DEPTH.
  assign end_clamped = (end_addr > DEPTH_C) ? DEPTH_C : end_addr;
  assign start_acc   = start && !abort && (state_q == IDLE);
  assign accept      = out_valid && bus.out_ready;
  assign last        = ((cnt_q + ONE) == bound_q);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state and per-state strobes; abort overrides everything.
  always_comb begin
    state_d = state_q;
    rd_en   = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      IDLE:    if (start_acc) state_d = (start_addr >= end_clamped) ? FIN : ISSUE;
      ISSUE: begin
        rd_en   = 1'b1;
        state_d = CAPTURE;
      end
      CAPTURE: begin
        load    = 1'b1;
        state_d = HOLD;
      end
      HOLD:    if (accept) state_d = last ? FIN : ISSUE;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
      load    = 1'b0;
    end
  end

  // Address counter and bound; counter is one bit wider than the RAM address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      bound_q <= '0;
    end else if (start_acc) begin
      cnt_q   <= start_addr;
      bound_q <= end_clamped;
    end else if ((state_q == HOLD) && accept && !abort && !last) begin
      cnt_q   <= cnt_q + ONE;
    end
  end

  mem_dump_out_reg #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_out (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (load),
    .flush     (abort),
    .ready     (bus.out_ready),
    .load_addr (cnt_q[ADDR_W-1:0]),
    .load_data (bus.rd_data),
    .valid     (out_valid),
    .addr      (out_addr),
    .data      (out_data)
  );

  assign bus.rd_en     = rd_en;
  assign bus.rd_addr   = rd_en ? cnt_q[ADDR_W-1:0] : '0;
  assign bus.out_valid = out_valid;
  assign bus.out_addr  = out_addr;
  assign bus.out_data  = out_data;
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == FIN);

`ifdef MEM_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] cs_q;
  logic              cs_vld_q;

  // Running sum of accepted words; flagged valid on entry to FIN.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cs_q     <= '0;
      cs_vld_q <= 1'b0;
    end else if (start_acc) begin
      cs_q     <= '0;
      cs_vld_q <= 1'b0;
    end else begin
      if ((state_q == HOLD) && accept && !abort) cs_q <= cs_q + out_data;
      if ((state_d == FIN) && (state_q != FIN))  cs_vld_q <= 1'b1;
    end
  end

  assign checksum       = cs_q;
  assign checksum_valid = cs_vld_q;
`endif

endmodule

// File: tb/tb_mem_dump_reader.sv
// Scoreboard bench for mem_dump_reader: stimulus pushes expected beats and
// done markers, a negedge monitor pops and compares. MEM_DUMP_CHECKSUM_EN
// adds checksum comparisons at done.
module tb_mem_dump_reader;
  import mem_dump_pkg::*;

  localparam int DATA_W = DEF_DATA_W;
  localparam int DEPTH  = DEF_DEPTH;
  localparam int AW     = addr_w(DEPTH);

  typedef struct {
    bit              is_done;
    logic [AW-1:0]   addr;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] cs;
    bit              lat;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n, start, abort;
  logic [AW:0] start_addr, end_addr;
  logic busy, done;
`ifdef MEM_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] checksum;
  logic checksum_valid;
`endif

  mem_dump_reader_if #(.DATA_W(DATA_W), .ADDR_W(AW)) bus ();

  mem_dump_reader #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .abort      (abort),
    .start_addr (start_addr),
    .end_addr   (end_addr),
    .busy       (busy),
    .done       (done),
`ifdef MEM_DUMP_CHECKSUM_EN
    .checksum       (checksum),
    .checksum_valid (checksum_valid),
`endif
    .bus        (bus)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] ram [DEPTH];
  always @(posedge clk) if (bus.rd_en) bus.rd_data <= ram[bus.rd_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   total = 0, bad = 0;
  exp_t exp_q[$];
  int   rd_cnt = 0, last_acc = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic push_beat(input int a, input int d);
    exp_t e;
    e.is_done = 1'b0; e.addr = AW'(a); e.data = DATA_W'(d); e.cs = '0; e.lat = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic push_done(input int cs, input bit lat);
    exp_t e;
    e.is_done = 1'b1; e.addr = '0; e.data = '0; e.cs = DATA_W'(cs); e.lat = lat;
    exp_q.push_back(e);
  endtask

  task automatic pulse_start(input int sa, input int ea);
    @(posedge clk); #1;
    start = 1'b1; start_addr = (AW+1)'(sa); end_addr = (AW+1)'(ea);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget, input bit tog);
    int n = 0;
    forever begin
      @(negedge clk);
      if ((!busy && exp_q.size() == 0) || n >= budget) break;
      @(posedge clk); #1;
      if (tog) bus.out_ready = ~bus.out_ready;
      n++;
    end
    chk({name, "_drain"}, exp_q.size(), 0);
    chk({name, "_idle"}, busy, 0);
  endtask

  // Monitor: compares accepted beats and done pulses against the queue and
  // checks that a stalled word stays put unless an abort intervened.
  exp_t              mon_e;
  logic              stall_q = 1'b0, abort_q = 1'b0;
  logic [AW-1:0]     st_addr;
  logic [DATA_W-1:0] st_data;
  initial forever begin
    @(negedge clk);
    if (!reset_n) begin
      stall_q = 1'b0;
    end else begin
      if (bus.rd_en) rd_cnt++;
      if (stall_q && !abort_q)
        chk("stall_hold", {bus.out_valid, bus.out_addr, bus.out_data}, {1'b1, st_addr, st_data});
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0 || exp_q[0].is_done) begin
          total++; bad++;
          $display("FAIL unexpected_beat got=%0h:%0h exp=none", bus.out_addr, bus.out_data);
        end else begin
          mon_e = exp_q.pop_front();
          chk("beat", {bus.out_addr, bus.out_data}, {mon_e.addr, mon_e.data});
          last_acc = cyc;
        end
      end
      if (done) begin
        if (exp_q.size() == 0 || !exp_q[0].is_done) begin
          total++; bad++;
          $display("FAIL unexpected_done got=1 exp=0");
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.lat) chk("done_lat", cyc - last_acc, 1);
`ifdef MEM_DUMP_CHECKSUM_EN
          chk("checksum", {checksum_valid, checksum}, {1'b1, mon_e.cs});
`endif
        end
      end
      stall_q = bus.out_valid && !bus.out_ready;
      st_addr = bus.out_addr;
      st_data = bus.out_data;
      abort_q = abort;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset_n = 1'b0; start = 1'b0; abort = 1'b0;
    start_addr = '0; end_addr = '0; bus.out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) ram[i] = DATA_W'(8'hA0 + i);

    repeat (2) @(posedge clk); #1;
    chk("reset_outs", {busy, done, bus.rd_en, bus.rd_addr, bus.out_valid, bus.out_addr, bus.out_data}, 0);
`ifdef MEM_DUMP_CHECKSUM_EN
    chk("reset_cs", {checksum_valid, checksum}, 0);
`endif
    reset_n = 1'b1;

    // 1: plain dump [0,4), sink always ready, 3-clk first-word latency.
    bus.out_ready = 1'b1; rd_cnt = 0;
    for (int i = 0; i < 4; i++) push_beat(i, 8'hA0 + i);
    push_done(8'h86, 1'b1);
    pulse_start(0, 4);
    @(negedge clk); chk("t1_lat_issue", bus.out_valid, 0);
    @(negedge clk); chk("t1_lat_capture", bus.out_valid, 0);
    @(negedge clk); chk("t1_lat_hold", bus.out_valid, 1);
    wait_idle("t1", 60, 1'b0);
    chk("t1_reads", rd_cnt, 4);

    // 2: same dump with the sink toggling ready every cycle.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_beat(i, 8'hA0 + i);
    push_done(8'h86, 1'b1);
    pulse_start(0, 4);
    wait_idle("t2", 80, 1'b1);

    // 3: empty range -> done next cycle, no reads, no beats.
    bus.out_ready = 1'b1; rd_cnt = 0;
    push_done(8'h00, 1'b0);
    pulse_start(16, 16);
    @(negedge clk); chk("t3_done", done, 1);
    wait_idle("t3", 10, 1'b0);
    chk("t3_reads", rd_cnt, 0);

    // 4: end beyond DEPTH clamps; a start while busy is ignored.
    rd_cnt = 0;
    for (int i = 12; i < 16; i++) push_beat(i, 8'hA0 + i);
    push_done(8'hB6, 1'b1);
    pulse_start(12, DEPTH + 5);
    pulse_start(0, 2);
    wait_idle("t4", 60, 1'b0);
    chk("t4_reads", rd_cnt, 4);

    // 5: abort while beat 2 is held, then restart from a new address.
    push_beat(0, 8'hA0); push_beat(1, 8'hA1);
    pulse_start(0, 8);
    n = 0;
    do begin @(negedge clk); n++; end while (!(bus.out_valid && bus.out_addr == 1) && n < 40);
    @(posedge clk); #1; bus.out_ready = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.out_valid && n < 40);
    chk("t5_held_addr", bus.out_addr, 2);
    @(posedge clk); #1; abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    @(negedge clk); chk("t5_after_abort", {bus.out_valid, busy, done}, 0);
    repeat (3) @(negedge clk);
    chk("t5_queue", exp_q.size(), 0);
    bus.out_ready = 1'b1;
    push_beat(5, 8'hA5); push_beat(6, 8'hA6);
    push_done(8'h4B, 1'b1);
    pulse_start(5, 7);
    wait_idle("t5", 40, 1'b0);

    // 6: checksum wraps mod 2^DATA_W, then async reset mid-dump.
    ram[0] = 8'hFF; ram[1] = 8'h02;
    push_beat(0, 8'hFF); push_beat(1, 8'h02);
    push_done(8'h01, 1'b1);
    pulse_start(0, 2);
    wait_idle("t6", 40, 1'b0);
`ifdef MEM_DUMP_CHECKSUM_EN
    @(negedge clk); chk("t6_cs_hold", {checksum_valid, checksum}, {1'b1, 8'h01});
`endif
    bus.out_ready = 1'b0;
    pulse_start(0, 8);
    repeat (4) @(posedge clk);
    #3 reset_n = 1'b0;
    #1 chk("t6_async_rst", {busy, done, bus.rd_en, bus.rd_addr, bus.out_valid, bus.out_addr, bus.out_data}, 0);
`ifdef MEM_DUMP_CHECKSUM_EN
    chk("t6_rst_cs", {checksum_valid, checksum}, 0);
`endif
    exp_q.delete();
    @(posedge clk); #1; reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6_stays_idle", {busy, bus.out_valid}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
